mem_tag_ctrl: RTL and testbench
===============================

MEM_TAG_CTRL -- requirements
Module: mem_tag_ctrl

Interface
REQ-001 Parameter DATA_W, 64, memory line width in bits; a power of two of at least 8.
REQ-002 Parameter DEPTH, 8192, number of DATA_W-bit lines; a power of two.
REQ-003 Parameter LATENCY, 4, cycles from load accept to data return; range 1..16.
REQ-004 Parameter MAX_OUTSTANDING, 4, maximum loads in flight; range 1..15.
REQ-005 Port clock  in  1  system clock; all state changes on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port proc2mem_command  in  2  command: 0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE).
REQ-008 Port proc2mem_addr  in  XLEN  byte address; line index = addr[log2(DATA_W/8) +: log2(DEPTH)].
REQ-009 Port proc2mem_data  in  DATA_W  store data, aligned to the line.
REQ-010 Port proc2mem_size  in  2  store size: 0=BYTE, 1=HALF, 2=WORD, 3=DOUBLE; present only with MEM_BYTE_WRITE_EN.
REQ-011 Port mem2proc_response  out  4  tag assigned to the accepted command; 0 means rejected.
REQ-012 Port mem2proc_data  out  DATA_W  returned load line; 0 when mem2proc_tag is 0.
REQ-013 Port mem2proc_tag  out  4  tag of the returning load; 0 means no return this cycle.
REQ-014 Port mem_error  out  1  sticky flag for an out-of-range access.

Function
REQ-015 mem2proc_response SHALL be combinational from the current cycle's command and state.
REQ-016 A LOAD or STORE SHALL be accepted when the address is in range and, for LOAD, outstanding < MAX_OUTSTANDING; otherwise response SHALL be 0.
REQ-017 An accepted command SHALL receive the next tag from a 4-bit counter that cycles 1..15 (15 wraps to 1, 0 skipped); the counter advances only on accept.
REQ-018 An accepted STORE SHALL write the line at that rising edge; no data return follows.
REQ-019 An accepted LOAD SHALL read the line at the accept edge into a LATENCY-stage shift pipeline of {valid, tag, data}.
REQ-020 mem2proc_tag and mem2proc_data SHALL present the last pipeline stage exactly LATENCY cycles after the accept edge, for one cycle only.
REQ-021 A LOAD accepted one cycle after a STORE to the same line SHALL return the stored data.
REQ-022 The outstanding counter SHALL increment on an accepted LOAD and decrement on a return; when both occur in the same cycle it SHALL hold, and that cycle's LOAD SHALL be judged against the pre-edge count.
REQ-023 An out-of-range address on LOAD or STORE SHALL set mem_error until reset; memory SHALL NOT be modified.
REQ-024 Command 3 and NONE SHALL give response 0, change no state and set no error.

Reset
REQ-025 While reset is low, these SHALL clear asynchronously: all pipeline stages invalid, outstanding=0, tag counter=1, mem_error=0, mem2proc_tag=0, mem2proc_data=0.
REQ-026 Loads in flight at reset assertion SHALL be discarded with no return; memory contents SHALL be retained through reset.
REQ-027 Outputs driven from state SHALL be low during reset; response SHALL be 0 during reset regardless of command.

Configuration
REQ-028 Macro MEM_BYTE_WRITE_EN SHALL enable the proc2mem_size port and store byte masking.
REQ-029 With MEM_BYTE_WRITE_EN defined, a STORE SHALL write only the addressed naturally-aligned BYTE/HALF/WORD/DOUBLE lanes, selected by the low address bits; other bytes SHALL be preserved.
REQ-030 With MEM_BYTE_WRITE_EN undefined, a STORE SHALL write the full DATA_W line and the size port SHALL be absent.

Verification
REQ-031 LOAD addr 0x40 after reset, with line preloaded to 0x1122334455667788 -> response 1; 4 cycles later tag=1 and data=0x1122334455667788 for exactly one cycle.
REQ-032 Five LOADs back-to-back with LATENCY=4 and MAX_OUTSTANDING=4 -> responses 1,2,3,4,0; the next LOAD, in the cycle tag 1 returns, is accepted with tag 5.
REQ-033 Issue 15 STOREs then one LOAD -> tags 1..15, then 1 (wrap); tag 0 is never issued.
REQ-034 With MEM_BYTE_WRITE_EN: STORE BYTE 0xAB to addr 0x103 on a zero line, then LOAD 0x100 -> data 0x00000000AB000000.
REQ-035 LOAD addr = DEPTH*8 -> response 0, mem_error=1 and held; the next valid LOAD returns normally.
REQ-036 Assert reset 2 cycles after a LOAD is accepted -> no return occurs after release, and the next accepted command gets tag 1.

Source files
------------

// File: rtl/mem_tag_ctrl.sv
// Tagged fixed-latency line memory with a bounded number of loads in flight.
// Define MEM_BYTE_WRITE_EN for sized, byte-masked stores.
module mem_tag_ctrl #(
   parameter int DATA_W          = 64,
   parameter int DEPTH           = 8192,
   parameter int LATENCY         = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int XLEN            = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        proc2mem_command,
   input  logic [XLEN-1:0]   proc2mem_addr,
   input  logic [DATA_W-1:0] proc2mem_data,
`ifdef MEM_BYTE_WRITE_EN
   input  logic [1:0]        proc2mem_size,
`endif
   output logic [3:0]        mem2proc_response,
   output logic [DATA_W-1:0] mem2proc_data,
   output logic [3:0]        mem2proc_tag,
   output logic              mem_error
);
   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH);

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [LATENCY-1:0] pv_q;
   logic [3:0]         pt_q [LATENCY];
   logic [DATA_W-1:0]  pd_q [LATENCY];
   logic [3:0]         tag_q, tag_d;
   logic [3:0]         out_q, out_d;
   logic [3:0]         rtag_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               err_q;
   logic [IDXW-1:0]    idx;
   logic               is_ld, is_st, in_rng;
   logic               acc_ld, acc_st, ret;
   logic [NB-1:0]      be;

   assign idx    = proc2mem_addr[OFFW +: IDXW];
   assign in_rng = (proc2mem_addr >> (OFFW + IDXW)) == '0;
   assign is_ld  = reset && (proc2mem_command == 2'd1);
   assign is_st  = reset && (proc2mem_command == 2'd2);
   assign acc_ld = is_ld && in_rng && (out_q < 4'(MAX_OUTSTANDING));
   assign acc_st = is_st && in_rng;
   assign ret    = pv_q[LATENCY-1];

   assign mem2proc_response = (acc_ld || acc_st) ? tag_q : 4'd0;
   assign mem2proc_tag      = rtag_q;
   assign mem2proc_data     = rdata_q;
   assign mem_error         = err_q;

   // A load leaving the last stage frees its slot in the same edge.
   always_comb begin
      tag_d = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
      unique case ({acc_ld, ret})
         2'b10:   out_d = out_q + 4'd1;
         2'b01:   out_d = out_q - 4'd1;
         default: out_d = out_q;
      endcase
   end

`ifdef MEM_BYTE_WRITE_EN
   logic [XLEN-1:0] boff;
   assign boff = proc2mem_addr & XLEN'(NB - 1);

   // Lane b is written when it shares all offset bits above the size.
   always_comb begin
      be = '0;
      for (int b = 0; b < NB; b++)
         be[b] = ((XLEN'(b) ^ boff) >> proc2mem_size) == '0;
   end
`else
   assign be = '1;
`endif

   always_ff @(posedge clock) begin
      if (acc_st)
         for (int b = 0; b < NB; b++)
            if (be[b])
               mem[idx][b*8 +: 8] <= proc2mem_data[b*8 +: 8];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pv_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pt_q[i] <= '0;
            pd_q[i] <= '0;
         end
         tag_q   <= 4'd1;
         out_q   <= '0;
         err_q   <= 1'b0;
         rtag_q  <= '0;
         rdata_q <= '0;
      end else begin
         pv_q[0] <= acc_ld;
         if (acc_ld) begin
            pt_q[0] <= tag_q;
            pd_q[0] <= mem[idx];
         end
         for (int i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pt_q[i] <= pt_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
         rtag_q  <= ret ? pt_q[LATENCY-1] : 4'd0;
         rdata_q <= ret ? pd_q[LATENCY-1] : '0;
         out_q   <= out_d;
         if (acc_ld || acc_st)
            tag_q <= tag_d;
         if ((is_ld || is_st) && !in_rng)
            err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_tag_ctrl.sv
// Self-checking bench for mem_tag_ctrl: directed tables plus random
// traffic against a queue-based reference model.
module tb_mem_tag_ctrl;
   localparam int LAT   = 4;
   localparam int MAXO  = 4;
   localparam int LIMIT = 8192 * 8;
`ifdef MEM_BYTE_WRITE_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd   = 2'd0;
   logic [31:0] addr  = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  size  = 2'd3;
   logic [3:0]  resp, mtag;
   logic [63:0] mdata;
   logic        merr;

   mem_tag_ctrl #(
      .DATA_W(64), .DEPTH(8192), .LATENCY(LAT),
      .MAX_OUTSTANDING(MAXO), .XLEN(32)
   ) dut (
      .clock(clock),
      .reset(reset),
      .proc2mem_command(cmd),
      .proc2mem_addr(addr),
      .proc2mem_data(wdata),
`ifdef MEM_BYTE_WRITE_EN
      .proc2mem_size(size),
`endif
      .mem2proc_response(resp),
      .mem2proc_data(mdata),
      .mem2proc_tag(mtag),
      .mem_error(merr)
   );

   initial forever #5 clock = ~clock;

   typedef struct {
      int         due;
      logic [3:0] tag;
      logic [63:0] data;
   } ret_t;

   typedef struct {
      logic [1:0]  c;
      logic [31:0] a;
      logic [3:0]  resp;
      logic [3:0]  tag;
      logic [63:0] data;
   } vec_t;

   ret_t        q[$];
   logic [63:0] mem_m [int];
   logic [3:0]  ntag  = 4'd1;
   logic        err_m = 1'b0;
   int          cyc_n = 0;
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  s_resp, s_tag;
   logic [63:0] s_data;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] mrd(input int ln);
      return mem_m.exists(ln) ? mem_m[ln] : 64'bx;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old,
         input logic [63:0] d, input logic [31:0] a, input logic [1:0] s);
      int nb, base;
      logic [63:0] r;
      if (!BYTE_EN) return d;
      nb   = 1 << int'(s);
      base = (int'(a[2:0]) / nb) * nb;
      r    = old;
      for (int b = 0; b < 8; b++)
         if (b >= base && b < base + nb) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // One clock cycle: drive, compare against the model, advance.
   task automatic cyc(input logic [1:0] c, input logic [31:0] a,
                      input logic [63:0] d, input logic [1:0] s);
      logic [3:0]  et, er;
      logic [63:0] ed;
      bit          acc;
      int          ln;
      cmd = c; addr = a; wdata = d; size = s;
      #2;
      et = 4'd0; ed = 64'd0;
      if (q.size() > 0 && q[0].due == cyc_n) begin
         et = q[0].tag;
         ed = q[0].data;
         void'(q.pop_front());
      end
      acc = (a < 32'(LIMIT)) &&
            (c == 2'd2 || (c == 2'd1 && q.size() < MAXO));
      er  = acc ? ntag : 4'd0;
      s_resp = resp; s_tag = mtag; s_data = mdata;
      chk("resp", 64'(resp), 64'(er));
      chk("ret_tag", 64'(mtag), 64'(et));
      chk("ret_data", mdata, ed);
      chk("mem_error", 64'(merr), 64'(err_m));
      ln = int'(a[15:3]);
      if ((c == 2'd1 || c == 2'd2) && a >= 32'(LIMIT)) err_m = 1'b1;
      if (acc && c == 2'd1) q.push_back('{cyc_n + LAT + 1, ntag, mrd(ln)});
      if (acc && c == 2'd2) mem_m[ln] = merge(mrd(ln), d, a, s);
      if (acc) ntag = (ntag == 4'd15) ? 4'd1 : ntag + 4'd1;
      @(posedge clock); #1;
      cyc_n++;
   endtask

   task automatic do_reset();
      reset = 1'b0; cmd = 2'd1; addr = 32'h40;
      #2;
      chk("rst_resp", 64'(resp), 64'd0);
      chk("rst_tag", 64'(mtag), 64'd0);
      chk("rst_data", mdata, 64'd0);
      chk("rst_err", 64'(merr), 64'd0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      cmd = 2'd0; reset = 1'b1;
      cyc_n += 2;
      q.delete();
      ntag  = 4'd1;
      err_m = 1'b0;
   endtask

   localparam logic [63:0] D40 = 64'h1122334455667788;
   localparam logic [63:0] D48 = 64'hA5A5_0F0F_C3C3_7E7E;
   localparam logic [63:0] D50 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] D58 = 64'hDEAD_BEEF_CAFE_F00D;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{2'd1, 32'h40, 4'd1, 4'd0, 64'd0};
      tbl[1]  = '{2'd1, 32'h48, 4'd2, 4'd0, 64'd0};
      tbl[2]  = '{2'd1, 32'h50, 4'd3, 4'd0, 64'd0};
      tbl[3]  = '{2'd1, 32'h58, 4'd4, 4'd0, 64'd0};
      tbl[4]  = '{2'd1, 32'h40, 4'd0, 4'd0, 64'd0};
      tbl[5]  = '{2'd1, 32'h48, 4'd5, 4'd1, D40};
      tbl[6]  = '{2'd0, 32'h40, 4'd0, 4'd2, D48};
      tbl[7]  = '{2'd3, 32'h40, 4'd0, 4'd3, D50};
      tbl[8]  = '{2'd0, 32'h40, 4'd0, 4'd4, D58};
      tbl[9]  = '{2'd0, 32'h40, 4'd0, 4'd0, 64'd0};
      tbl[10] = '{2'd0, 32'h40, 4'd0, 4'd5, D48};
      tbl[11] = '{2'd0, 32'h40, 4'd0, 4'd0, 64'd0};

      #1 reset = 1'b0;
      do_reset();

      // Preload, then reset: memory must survive reset.
      cyc(2'd2, 32'h40, D40, 2'd3);
      cyc(2'd2, 32'h48, D48, 2'd3);
      cyc(2'd2, 32'h50, D50, 2'd3);
      cyc(2'd2, 32'h58, D58, 2'd3);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].c, tbl[i].a, 64'd0, 2'd3);
         chk($sformatf("tbl%0d_resp", i), 64'(s_resp), 64'(tbl[i].resp));
         chk($sformatf("tbl%0d_tag", i), 64'(s_tag), 64'(tbl[i].tag));
         chk($sformatf("tbl%0d_data", i), s_data, tbl[i].data);
      end

      // Reset two cycles after an accepted load drops it.
      cyc(2'd1, 32'h40, 64'd0, 2'd3);
      cyc(2'd0, 32'h0, 64'd0, 2'd3);
      cyc(2'd0, 32'h0, 64'd0, 2'd3);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'd0, 32'h0, 64'd0, 2'd3);
      cyc(2'd2, 32'h48, D48, 2'd3);
      chk("post_rst_tag", 64'(s_resp), 64'd1);

      // Reserved command never flags an error.
      cyc(2'd3, 32'h10000, 64'd0, 2'd3);
      cyc(2'd0, 32'h0, 64'd0, 2'd3);
      chk("rsv_no_err", 64'(merr), 64'd0);

      // Out-of-range load/store: error sticks, memory untouched.
      cyc(2'd1, 32'h10000, 64'd0, 2'd3);
      cyc(2'd2, 32'h10040, ~64'd0, 2'd3);
      cyc(2'd0, 32'h0, 64'd0, 2'd3);
      chk("oor_err", 64'(merr), 64'd1);
      cyc(2'd1, 32'h40, 64'd0, 2'd3);
      for (int i = 0; i < 5; i++) cyc(2'd0, 32'h0, 64'd0, 2'd3);
      chk("oor_ret", s_data, D40);
      chk("oor_err_held", 64'(merr), 64'd1);

      // Tag wrap: 15 stores then a load.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(2'd2, 32'h200 + 32'(8 * i), {$urandom, $urandom}, 2'd3);
         chk($sformatf("wrap_st%0d", i), 64'(s_resp), 64'(i + 1));
      end
      cyc(2'd1, 32'h200, 64'd0, 2'd3);
      chk("wrap_ld", 64'(s_resp), 64'd1);
      for (int i = 0; i < 6; i++) cyc(2'd0, 32'h0, 64'd0, 2'd3);

`ifdef MEM_BYTE_WRITE_EN
      cyc(2'd2, 32'h100, 64'd0, 2'd3);
      cyc(2'd2, 32'h103, 64'h00000000AB000000, 2'd0);
      cyc(2'd1, 32'h100, 64'd0, 2'd3);
      for (int i = 0; i < 5; i++) cyc(2'd0, 32'h0, 64'd0, 2'd3);
      chk("byte_store", s_data, 64'h00000000AB000000);
`endif

      for (int i = 0; i < 400; i++) begin
         int k, w;
         logic [1:0]  c;
         logic [31:0] a;
         if (i == 200) do_reset();
         k = $urandom_range(0, 18);
         w = $urandom_range(0, 99);
         c = (w < 20) ? 2'd0 : (w < 65) ? 2'd1 : (w < 90) ? 2'd2 : 2'd3;
         if ($urandom_range(0, 15) == 0)
            a = 32'h10000 + 32'($urandom_range(0, 4095));
         else if (k < 4)
            a = 32'h40 + 32'(8 * k) + 32'($urandom_range(0, 7));
         else
            a = 32'h200 + 32'(8 * (k - 4)) + 32'($urandom_range(0, 7));
         cyc(c, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 8; i++) cyc(2'd0, 32'h0, 64'd0, 2'd3);
      chk("drained", 64'(q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
